// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// slave is the queue side, master is the fetch/decode/execute side.
interface fetch_queue_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_instr;
    logic [ADDRESS_WIDTH-1:0] in_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_instr;
    logic [ADDRESS_WIDTH-1:0] out_pc;
    logic [ADDRESS_WIDTH-1:0] out_pcplus4;
    logic [CW-1:0]            count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_pcplus4, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_pcplus4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular {instr, pc} buffer between fetch and decode; NOP when empty.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    instr;
        logic [ADDRESS_WIDTH-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     wrPtr;
    logic [CW-1:0]     cnt;
    logic              empty;
    logic              full;
    logic              bypass;
    logic              push;
    logic              pop;

    always_comb begin
        empty  = (cnt == '0);
        full   = (cnt == FULL);
        head   = mem[rdPtr];
        bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty && bus.in_valid && !bus.flush;
`endif
        // A bypassed instruction taken by decode never enters storage
        push = bus.in_valid && !full && !bus.flush
               && !(bypass && bus.out_ready);
        pop  = !empty && bus.out_ready && !bus.flush;
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty || bypass;
    assign bus.count     = cnt;

    always_comb begin
        bus.out_instr   = NOP;
        bus.out_pc      = '0;
        bus.out_pcplus4 = '0;
        unique case (1'b1)
            !empty: begin
                bus.out_instr   = head.instr;
                bus.out_pc      = head.pc;
                bus.out_pcplus4 = head.pc + ADDRESS_WIDTH'(4);
            end
            bypass: begin
                bus.out_instr   = bus.in_instr;
                bus.out_pc      = bus.in_pc;
                bus.out_pcplus4 = bus.in_pc + ADDRESS_WIDTH'(4);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else if (bus.flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            unique case (1'b1)
                push && !pop: cnt <= cnt + CW'(1);
                pop && !push: cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= '{instr: bus.in_instr, pc: bus.in_pc};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt <= FULL);
            assert (!(pop && empty));
            assert (!(push && !pop && full));
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage (`instr_mem` read + PC register) and the decode pipeline register of the 5-stage `risc_v` core. Holds up to `DEPTH` fetched {instruction, PC} pairs, so decode can stall without re-fetching. Flushes all contents on a taken branch or jump redirect from execute. Presents a NOP (`addi x0,x0,0`) to decode whenever it holds nothing valid.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, PC width.
- `DATA_WIDTH`, 32, instruction width.
- `DEPTH`, 4, number of entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `flush`  in  1  redirect (driven by `PCSrcE`). Discards all entries.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  queue accepts this cycle.
- `in_instr`  in  `DATA_WIDTH`  fetched instruction (`instrF`).
- `in_pc`  in  `ADDRESS_WIDTH`  its PC (`PCF`).
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head (not stalled).
- `out_instr`  out  `DATA_WIDTH`  head instruction; 32'h0000_0013 when `out_valid`=0.
- `out_pc`  out  `ADDRESS_WIDTH`  head PC; 0 when `out_valid`=0.
- `out_pcplus4`  out  `ADDRESS_WIDTH`  `out_pc`+4 (modulo 2^`ADDRESS_WIDTH`); 0 when `out_valid`=0.
- `count`  out  $clog2(`DEPTH`+1)  occupancy.

## Operation
- Storage: circular buffer of `DEPTH` entries, each {instr, pc}. Read and write pointers are $clog2(`DEPTH`) bits and wrap naturally from `DEPTH`-1 to 0.
- Occupancy counter `count` ranges 0..`DEPTH`.
- Push fires when `in_valid && in_ready && !flush`. It writes the entry at the write pointer and advances the write pointer.
- Pop fires when `out_valid && out_ready && !flush`. It advances the read pointer.
- `in_ready` = (`count` != `DEPTH`). It is combinational from registered state only and never depends on `out_ready`.
- `out_valid` = (`count` != 0). The `out_*` data fields come from the entry at the read pointer.
- Simultaneous push and pop with 0 < `count` < `DEPTH`: `count` is unchanged and both pointers advance.
- Full (`count`=`DEPTH`): `in_valid` is ignored, and fetch must hold its PC. A pop in the same cycle still fires; the freed slot is usable the following cycle.
- Empty: `out_ready` is ignored, and outputs show the NOP/zero values.
- Flush has priority over everything. At the next edge: pointers ← 0, `count` ← 0. The same-cycle push and pop are both discarded. Entry storage contents are don't-care.
- Pointer/count arithmetic: `count` is updated by +1, -1 or 0. It never exceeds `DEPTH` and never underflows; an assertion checks both.

## Timing
- Reset (async assert, released synchronously to `clk` by the surrounding design): pointers 0, `count` 0. Therefore `out_valid`=0, `in_ready`=1, `out_instr`=32'h0000_0013, `out_pc`=0, `out_pcplus4`=0.
- Reset asserted mid-operation clears state immediately, without waiting for an edge. Entries are lost.
- Push-to-output latency is 1 cycle: an entry written at edge N is visible on `out_*` after edge N.
- Pop takes effect at the edge. The next entry (or NOP) appears after that edge.
- After a flush at edge N: `out_valid`=0 and `in_ready`=1 in cycle N+1. The redirected fetch can push in cycle N+1.
- No combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`, unless `FETCH_QUEUE_BYPASS_EN` is defined.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count`=0 and `in_valid` is high, `out_valid`=1 and `out_*` show `in_instr`/`in_pc` combinationally.
  - If `out_ready` is also high, the instruction is consumed and not stored: `count` stays 0.
  - Otherwise it is pushed normally.
  - `flush` still suppresses the bypass: `out_valid`=0 during a flush cycle.
  - Empty-queue latency becomes 0 cycles.
- Not defined: strict 1-cycle latency as described above, with no bypass logic.

## Test plan
- Reset/idle: assert `rst` for 2 cycles, then release. Expect `count`=0, `out_valid`=0, `in_ready`=1, `out_instr`=32'h0000_0013, `out_pc`=0.
- Fill to full: `out_ready`=0, push PCs 0x0, 0x4, 0x8, 0xC. Expect `count`=4, `in_ready`=0. A 5th push (PC 0x10) is not accepted. `out_pc`=0x0, `out_pcplus4`=0x4.
- Drain with wrap: from full, pop 2 and push PCs 0x10, 0x14 (pointer wraps to 0, then 1). Then drain all. Expect pop order 0x8, 0xC, 0x10, 0x14.
- Simultaneous push/pop at `count`=2: hold `in_valid`=`out_ready`=1 for 6 cycles with incrementing PCs. Expect `count` constant at 2 and PCs emitted in order.
- Flush: with `count`=3, assert `flush` together with `in_valid` (PC 0x40) and `out_ready`. Expect next cycle `count`=0, `out_valid`=0, and 0x40 not stored. Push PC 0x80 in that cycle; expect `out_pc`=0x80 one cycle later.
- Async reset mid-stream: with `count`=2, assert `rst` between edges. Expect `count`=0 and `out_valid`=0 before the next rising edge. Also repeat the empty-queue push with `FETCH_QUEUE_BYPASS_EN` defined: `out_valid`=1 and `out_pc`=`in_pc` in the same cycle.
